// File: rtl/stream_block_capture.sv
// stream_block_capture: valid/ready stream sink that captures one block of
// len_i words into an internal buffer, readable through a registered
// random-access port. Pulses done_o after the last word of a block and
// err_o when a start request carries an illegal length.
//
// Optional feature macro: STREAM_READER_THROTTLE_EN
//   When defined, a free-running 16-bit LFSR throttles stream_s_ready_o
//   against rate_i. When undefined, rate_i is ignored and the sink is
//   always ready while receiving.
module stream_block_capture #(
    parameter int WIDTH          = 32,
    parameter int MAX_BLOCK_SIZE = 32,
    localparam int LW            = $clog2(MAX_BLOCK_SIZE + 1),
    localparam int AW            = $clog2(MAX_BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] stream_s_data_i,
    input  logic             stream_s_valid_i,
    output logic             stream_s_ready_o,
    input  logic             start_i,
    input  logic [LW-1:0]    len_i,
    input  logic [7:0]       rate_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LW-1:0]    count_o,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              ready;
    logic              hs;

    logic [WIDTH-1:0]  buf_mem [MAX_BLOCK_SIZE];

`ifdef STREAM_READER_THROTTLE_EN
    logic [15:0]       lfsr_q, lfsr_d;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) used as the throttle dice
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, reseeded on reset so throttling patterns are repeatable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Ready only while receiving and the LFSR low byte clears the threshold
    always_comb begin
        ready = (state_q == RECV) && (lfsr_q[7:0] >= rate_i);
    end
`else
    logic              unused_rate;

    assign unused_rate = ^rate_i;

    // Ready purely from registered state; never looks at valid
    always_comb begin
        ready = (state_q == RECV);
    end
`endif

    assign hs = ready && stream_s_valid_i;

    // Next-state logic: accept/reject starts, count handshakes, end of block
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if ((len_i != '0) && (len_i <= LW'(MAX_BLOCK_SIZE))) begin
                        state_d = RECV;
                        len_d   = len_i;
                        count_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                // start_i is deliberately ignored here
                if (hs) begin
                    count_d = count_q + LW'(1);
                    if (count_d == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; a mid-block reset abandons the block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Buffer write: word i of the block lands at address i; RAM is never cleared
    always_ff @(posedge clk) begin
        if (hs) begin
            buf_mem[count_q[AW-1:0]] <= stream_s_data_i;
        end
    end

    // Read port combinational lookup; old data is seen on a same-edge write
    always_comb begin
        rd_data_d = buf_mem[rd_addr_i];
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign stream_s_ready_o = ready;
    assign busy_o           = (state_q == RECV);
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign count_o          = count_q;
    assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_stream_block_capture.sv
// Directed testbench for stream_block_capture (WIDTH=32, MAX_BLOCK_SIZE=32).
module tb_stream_block_capture;

    localparam int WIDTH = 32;
    localparam int MAXB  = 32;
    localparam int LW    = 6;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             start;
    logic [LW-1:0]    len;
    logic [7:0]       rate;
    logic             busy;
    logic             done;
    logic             err;
    logic [LW-1:0]    count;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int stall_cnt;
    int t0;
    logic [WIDTH-1:0] exp_mem [MAXB];

    stream_block_capture #(.WIDTH(WIDTH), .MAX_BLOCK_SIZE(MAXB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_s_data_i  (data),
        .stream_s_valid_i (valid),
        .stream_s_ready_o (ready),
        .start_i          (start),
        .len_i            (len),
        .rate_i           (rate),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .count_o          (count),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word after 'gap' idle cycles and wait (bounded) for its handshake.
    task automatic push_word(input logic [WIDTH-1:0] d, input int gap);
        bit ok;
        valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        valid = 1'b1;
        data  = d;
        ok    = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            stall_cnt++;
            tick();
        end
        valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic do_start(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
        rd_addr = a;
        tick();
        check(tag, rd_data, e);
    endtask

    initial begin
        rst_n = 1'b0; data = '0; valid = 1'b0; start = 1'b0;
        len = '0; rate = 8'd0; rd_addr = '0; stall_cnt = 0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Block of 4, valid held high
        do_start(6'd4);
        check("b4_busy", busy, 1);
        check("b4_ready", ready, 1);
        t0 = cyc;
        push_word(32'h11, 0); valid = 1'b1;
        push_word(32'h22, 0); valid = 1'b1;
        push_word(32'h33, 0); valid = 1'b1;
        push_word(32'h44, 0);
        check("b4_cycles", cyc - t0, 4);
        check("b4_done", done, 1);
        check("b4_busy_after", busy, 0);
        check("b4_ready_after", ready, 0);
        check("b4_count", count, 4);
        tick();
        check("b4_done_one_cycle", done, 0);
        check("b4_count_hold", count, 4);
        read_check("b4_rd0", 5'd0, 32'h11);
        read_check("b4_rd1", 5'd1, 32'h22);
        read_check("b4_rd2", 5'd2, 32'h33);
        read_check("b4_rd3", 5'd3, 32'h44);

        // Full block of 32 with random gaps on valid
        done_cnt = 0;
        do_start(6'd32);
        for (int i = 0; i < MAXB; i++) begin
            exp_mem[i] = 32'hA000_0000 + 32'(i * 3);
            push_word(exp_mem[i], int'($urandom_range(0, 2)));
            if (i == MAXB - 2) check("b32_no_early_done", done_cnt, 0);
        end
        check("b32_done", done, 1);
        check("b32_count", count, 32);
        valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("b32_ready_after_last", ready, 0);
            tick();
        end
        valid = 1'b0;
        check("b32_done_once", done_cnt, 1);
        for (int i = 0; i < MAXB; i++) read_check($sformatf("b32_rd%0d", i), AW'(i), exp_mem[i]);

        // Illegal lengths
        do_start(6'd0);
        check("len0_err", err, 1);
        check("len0_busy", busy, 0);
        check("len0_ready", ready, 0);
        tick();
        check("len0_err_pulse", err, 0);
        do_start(6'd33);
        check("len33_err", err, 1);
        check("len33_busy", busy, 0);
        check("len33_ready", ready, 0);
        tick();
        check("len33_err_pulse", err, 0);

        // start_i mid-block is ignored
        do_start(6'd8);
        for (int i = 0; i < 3; i++) push_word(32'hB0 + 32'(i), 0);
        start = 1'b1; len = 6'd2;
        push_word(32'hB3, 0);
        start = 1'b0;
        check("mid_no_err", err, 0);
        check("mid_busy", busy, 1);
        check("mid_count4", count, 4);
        for (int i = 4; i < 8; i++) push_word(32'hB0 + 32'(i), 0);
        check("mid_done", done, 1);
        check("mid_count", count, 8);
        read_check("mid_rd7", 5'd7, 32'hB7);

        // Reset in the middle of a block
        do_start(6'd6);
        push_word(32'hC0, 0);
        push_word(32'hC1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_ready", ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_count", count, 0);
        do_start(6'd2);
        push_word(32'h55, 0);
        push_word(32'h66, 0);
        check("mrst_done", done, 1);
        check("mrst_count2", count, 2);

        // Back-to-back: start accepted in the cycle done is high
        do_start(6'd1);
        check("b2b_busy", busy, 1);
        check("b2b_count_cleared", count, 0);
        push_word(32'h77, 0);
        check("b2b_done", done, 1);
        check("b2b_count", count, 1);
        read_check("mrst_rd0", 5'd0, 32'h77);
        read_check("mrst_rd1", 5'd1, 32'h66);
        read_check("ram_kept_rd2", 5'd2, 32'hB2);

        // 16 words at rate 0: one word per cycle in any build
        rate = 8'd0;
        do_start(6'd16);
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            push_word(32'hD00 + 32'(i), 0);
            valid = 1'b1;
        end
        valid = 1'b0;
        check("r0_cycles", cyc - t0, 16);
        check("r0_count", count, 16);
        read_check("r0_rd15", 5'd15, 32'hD0F);

`ifdef STREAM_READER_THROTTLE_EN
        // Throttled: rate 128 must stall at least once but lose nothing
        rate = 8'd128;
        stall_cnt = 0;
        do_start(6'd16);
        for (int i = 0; i < 16; i++) begin
            push_word(32'hE00 + 32'(i), 0);
            valid = 1'b1;
        end
        valid = 1'b0;
        check("thr_stalled", (stall_cnt > 0), 1);
        check("thr_count", count, 16);
        for (int i = 0; i < 16; i++) read_check($sformatf("thr_rd%0d", i), AW'(i), 32'hE00 + 32'(i));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_block_capture.md
# stream_block_capture

Streaming sink that receives a block of a programmed number of words from a valid/ready stream and stores them in an internal buffer, readable afterwards through a random-access read port. It is the receive endpoint for a memory-to-stream DMA writer in a bench or system. A completion pulse is generated at the end of each block, and backpressure can optionally be throttled.

## Interface
- WIDTH, 32, stream data word width in bits
- MAX_BLOCK_SIZE, 32, buffer depth in words; maximum block length
- LW, $clog2(MAX_BLOCK_SIZE+1), width of length/count fields (derived, not overridable)
- AW, $clog2(MAX_BLOCK_SIZE), buffer address width (derived)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- stream_s_data_i  in  WIDTH  stream data
- stream_s_valid_i  in  1  stream data valid
- stream_s_ready_o  out  1  sink ready
- start_i  in  1  one-cycle request to start receiving a block
- len_i  in  LW  block length in words, sampled with start_i
- rate_i  in  8  backpressure threshold (used only with throttling compiled in)
- busy_o  out  1  block reception in progress
- done_o  out  1  one-cycle pulse when the block completes
- err_o  out  1  one-cycle pulse when start_i is rejected
- count_o  out  LW  words received in the current or last block
- rd_addr_i  in  AW  buffer read address
- rd_data_o  out  WIDTH  buffer read data, registered

## Operation
- States: IDLE, RECV.
- IDLE + start_i + 1 ≤ len_i ≤ MAX_BLOCK_SIZE:
  - latch len_i
  - clear count_o
  - go to RECV
- IDLE + start_i + len_i == 0 or len_i > MAX_BLOCK_SIZE:
  - stay IDLE
  - err_o pulses
- start_i in RECV: ignored, no err_o.
- RECV:
  - Each handshake (valid & ready) writes stream_s_data_i to buffer[count] and increments count.
  - The handshake that makes count == len → IDLE; done_o pulses next cycle.
- Word i of the block is stored at buffer address i. Words beyond len are never accepted.
- stream_s_ready_o depends only on registered state, never on stream_s_valid_i. Readiness is 0 in IDLE.
- Buffer contents persist until overwritten. rd_data_o = buffer[rd_addr_i], registered.
- Reset mid-block: back to IDLE, count_o = 0, partial data is discarded logically. Buffer RAM is not cleared.

## Timing
- Reset values:
  - stream_s_ready_o, busy_o, done_o, err_o = 0
  - count_o = 0
  - rd_data_o = 0
- start_i sampled at edge T → busy_o = 1 and ready eligible from cycle T+1.
- Throughput: 1 word/cycle when unthrottled.
- Last handshake at edge E:
  - busy_o = 0 and stream_s_ready_o = 0 after E
  - done_o = 1 for exactly the cycle after E
  - count_o = len at that point, held until the next accepted start
- Back-to-back blocks: start_i is accepted in the cycle done_o is high.
- err_o is asserted the cycle after the rejected start_i.
- Read port latency: 1 cycle. Reading an address written on the same edge returns the old data.

## Configuration
- STREAM_READER_THROTTLE_EN defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 at reset, advances every cycle
  - stream_s_ready_o = (state==RECV) && (lfsr[7:0] >= rate_i)
  - rate_i = 0 means always ready in RECV
- Not defined: rate_i ignored; stream_s_ready_o = (state==RECV).

## Test plan
- len_i=4 with valid held high, data 0x11,0x22,0x33,0x44 → 4 consecutive handshakes; done_o pulses 1 cycle after the 4th; count_o=4; rd_addr 0..3 returns 0x11..0x44 with 1-cycle latency.
- len_i=32 (MAX) with random gaps on valid → all 32 words stored in order; done_o exactly once; ready never asserted after the 32nd word.
- start_i with len_i=0, then len_i=33 → err_o pulse each time; busy_o stays 0; ready stays 0.
- start_i asserted mid-block (len 8, after 3 words) → ignored; block completes after 8 words total; count_o=8.
- rst_n low after 2 of 6 words → next cycle ready=0, busy_o=0, count_o=0; a new start with len 2 captures the next 2 words at addresses 0,1.
- THROTTLE_EN with rate_i=128, len 16, valid held high → ready deasserts on some cycles; all 16 words are correct; rate_i=0 gives 16 consecutive handshakes.
